// File: rtl/mem_stage_pkg.sv
// ---------------------------------------------------------------------------
// mem_stage_pkg
// Constants shared by the pipeline stages (IF/ID/EX/MEM/WB) of the 5-stage
// MIPS core: datapath width, register-number width and data-memory depth.
// ---------------------------------------------------------------------------
package mem_stage_pkg;

  localparam int DATA_W          = 32;
  localparam int REG_ADDR_W      = 5;
  localparam int DMEM_DEPTH_LOG2 = 8;
  localparam int DMEM_DEPTH      = 1 << DMEM_DEPTH_LOG2;

endpackage : mem_stage_pkg

// File: rtl/mem_stage_data_memory.sv
// ---------------------------------------------------------------------------
// data_memory
// Word-wide data memory: synchronous write, asynchronous read gated by the
// read enable (a disabled read returns zero). A read and a write to the same
// word on the same edge return the old word; the new word is visible from
// the following cycle. Contents are not reset.
//
// Ports:
//   i_clk    clock, writes on rising edge
//   i_we     write enable (already qualified by the caller)
//   i_re     read enable; o_rdata is zero when low
//   i_index  word index
//   i_wdata  store data
//   o_rdata  combinational read data
// ---------------------------------------------------------------------------
module data_memory
  import mem_stage_pkg::*;
#(
  parameter int DATA_W     = mem_stage_pkg::DATA_W,
  parameter int DEPTH_LOG2 = mem_stage_pkg::DMEM_DEPTH_LOG2
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic                  i_re,
  input  logic [DEPTH_LOG2-1:0] i_index,
  input  logic [DATA_W-1:0]     i_wdata,
  output logic [DATA_W-1:0]     o_rdata
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_index] <= i_wdata;
    end
  end

  // Read sees the pre-edge contents, which gives old-data on a same-edge
  // read/write collision without any extra bypass logic.
  always_comb begin
    o_rdata = '0;
    if (i_re) begin
      o_rdata = r_mem[i_index];
    end
  end

endmodule : data_memory

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
// MEM stage of the 5-stage MIPS pipeline: performs the load/store against the
// data memory and registers the results into the MEM/WB pipeline register.
// The EX/MEM values needed by the forwarding unit are passed straight through
// combinationally. There is no handshake: the MEM/WB register updates on
// every rising edge.
//
// Ports:
//   CLK, RST            clock; synchronous active-high reset
//   ExRegWrite_in       RegWrite control from EX/MEM
//   ExMemtoReg_in       MemtoReg control from EX/MEM
//   address             ALU result: memory word index and pass-through value
//   writeData           store data
//   write_register      destination register number
//   MemRead, MemWrite   load / store enables
//   ExRegWrite_out_1    MEM/WB RegWrite
//   ExMemtoReg_out_1    MEM/WB MemtoReg
//   read_data_out_1     MEM/WB load data
//   mem_alu_result_1    MEM/WB ALU result
//   mem_write_reg_1     MEM/WB destination register
//   MEM_RegWrite_wire   forwarding copy of ExRegWrite_in
//   MEMRegRd_wire       forwarding copy of write_register
//   regExMem            forwarding copy of address
// ---------------------------------------------------------------------------
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_W     = mem_stage_pkg::DATA_W,
  parameter int DEPTH_LOG2 = mem_stage_pkg::DMEM_DEPTH_LOG2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  ExRegWrite_in,
  input  logic                  ExMemtoReg_in,
  input  logic [DATA_W-1:0]     address,
  input  logic [DATA_W-1:0]     writeData,
  input  logic [REG_ADDR_W-1:0] write_register,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  output logic                  ExRegWrite_out_1,
  output logic                  ExMemtoReg_out_1,
  output logic                  MEM_RegWrite_wire,
  output logic [DATA_W-1:0]     read_data_out_1,
  output logic [DATA_W-1:0]     mem_alu_result_1,
  output logic [REG_ADDR_W-1:0] mem_write_reg_1,
  output logic [REG_ADDR_W-1:0] MEMRegRd_wire,
  output logic [DATA_W-1:0]     regExMem
);

  logic              w_store_en;
  logic [DATA_W-1:0] w_rdata;

  // A store is suppressed on a reset edge; memory itself is never cleared.
  assign w_store_en = MemWrite & ~RST;

  data_memory #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_data_memory (
    .i_clk   (CLK),
    .i_we    (w_store_en),
    .i_re    (MemRead),
    .i_index (address[DEPTH_LOG2-1:0]),
    .i_wdata (writeData),
    .o_rdata (w_rdata)
  );

  // MEM/WB pipeline register. The reset branch is taken only for RST==1, so
  // an unknown RST falls through to the normal update.
  always_ff @(posedge CLK) begin
    if (RST == 1'b1) begin
      ExRegWrite_out_1 <= 1'b0;
      ExMemtoReg_out_1 <= 1'b0;
      read_data_out_1  <= '0;
      mem_alu_result_1 <= '0;
      mem_write_reg_1  <= '0;
    end else begin
      ExRegWrite_out_1 <= ExRegWrite_in;
      ExMemtoReg_out_1 <= ExMemtoReg_in;
      read_data_out_1  <= w_rdata;
      mem_alu_result_1 <= address;
      mem_write_reg_1  <= write_register;
    end
  end

  // Forwarding taps: unregistered and independent of reset.
  assign MEM_RegWrite_wire = ExRegWrite_in;
  assign MEMRegRd_wire     = write_register;
  assign regExMem          = address;

endmodule : mem_stage

// File: tb/tb_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_stage
// Directed plus short random stimulus for mem_stage. Each driven cycle pushes
// the expected MEM/WB contents (from a reference memory model) into a queue;
// after the rising edge the entry is popped and compared with the outputs.
// ---------------------------------------------------------------------------
module tb_mem_stage;

  localparam int DW = 32;
  localparam int RW = 5;

  typedef struct packed {
    logic          rw;
    logic          m2r;
    logic [DW-1:0] rdata;
    logic [DW-1:0] alu;
    logic [RW-1:0] wreg;
  } exp_t;

  // ---------------- clock / reset ----------------
  logic          CLK = 1'b0;
  logic          RST;
  logic          ExRegWrite_in;
  logic          ExMemtoReg_in;
  logic [DW-1:0] address;
  logic [DW-1:0] writeData;
  logic [RW-1:0] write_register;
  logic          MemRead;
  logic          MemWrite;
  logic          ExRegWrite_out_1;
  logic          ExMemtoReg_out_1;
  logic          MEM_RegWrite_wire;
  logic [DW-1:0] read_data_out_1;
  logic [DW-1:0] mem_alu_result_1;
  logic [RW-1:0] mem_write_reg_1;
  logic [RW-1:0] MEMRegRd_wire;
  logic [DW-1:0] regExMem;

  always #5 CLK = ~CLK;

  mem_stage dut (
    .CLK               (CLK),
    .RST               (RST),
    .ExRegWrite_in     (ExRegWrite_in),
    .ExMemtoReg_in     (ExMemtoReg_in),
    .address           (address),
    .writeData         (writeData),
    .write_register    (write_register),
    .MemRead           (MemRead),
    .MemWrite          (MemWrite),
    .ExRegWrite_out_1  (ExRegWrite_out_1),
    .ExMemtoReg_out_1  (ExMemtoReg_out_1),
    .MEM_RegWrite_wire (MEM_RegWrite_wire),
    .read_data_out_1   (read_data_out_1),
    .mem_alu_result_1  (mem_alu_result_1),
    .mem_write_reg_1   (mem_write_reg_1),
    .MEMRegRd_wire     (MEMRegRd_wire),
    .regExMem          (regExMem)
  );

  // ---------------- scoreboard ----------------
  exp_t          exp_q[$];
  logic [DW-1:0] model_mem [256];
  int            n_tests = 0;
  int            n_fail  = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Drives one cycle of inputs after the falling edge, records the expected
  // MEM/WB contents, then checks them 1ns after the next rising edge.
  task automatic step(input logic rst, input logic rw, input logic m2r,
                      input logic [DW-1:0] addr, input logic [DW-1:0] wd,
                      input logic [RW-1:0] wreg, input logic mr, input logic mw,
                      input string tag);
    exp_t e;
    exp_t got;
    @(negedge CLK);
    RST            = rst;
    ExRegWrite_in  = rw;
    ExMemtoReg_in  = m2r;
    address        = addr;
    writeData      = wd;
    write_register = wreg;
    MemRead        = mr;
    MemWrite       = mw;
    if (rst) begin
      e = '0;
    end else begin
      e.rw    = rw;
      e.m2r   = m2r;
      e.rdata = mr ? model_mem[addr[7:0]] : '0;
      e.alu   = addr;
      e.wreg  = wreg;
    end
    exp_q.push_back(e);
    if (mw && !rst) model_mem[addr[7:0]] = wd;
    @(posedge CLK);
    #1;
    n_tests++;
    assert (exp_q.size() > 0) else begin
      n_fail++;
      $error("FAIL %s_queue observed=empty expected=entry", tag);
    end
    if (exp_q.size() > 0) begin
      got = exp_q.pop_front();
      check({tag, "_rdata"}, read_data_out_1, got.rdata);
      check({tag, "_alu"},   mem_alu_result_1, got.alu);
      check({tag, "_wreg"},  {27'd0, mem_write_reg_1}, {27'd0, got.wreg});
      check({tag, "_rw"},    {31'd0, ExRegWrite_out_1}, {31'd0, got.rw});
      check({tag, "_m2r"},   {31'd0, ExMemtoReg_out_1}, {31'd0, got.m2r});
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [DW-1:0] a;
    for (int i = 0; i < 256; i++) model_mem[i] = '0;
    RST = 1'b1; ExRegWrite_in = 1'b0; ExMemtoReg_in = 1'b0;
    address = '0; writeData = '0; write_register = '0;
    MemRead = 1'b0; MemWrite = 1'b0;

    // Reset state, with forwarding taps live during reset.
    step(1'b1, 1'b1, 1'b1, 32'h0000_00AB, 32'h0, 5'd9, 1'b0, 1'b0, "reset0");
    check("fwd_in_reset_addr", regExMem, 32'h0000_00AB);
    check("fwd_in_reset_rd",   {27'd0, MEMRegRd_wire}, 32'd9);
    check("fwd_in_reset_rw",   {31'd0, MEM_RegWrite_wire}, 32'd1);

    // Give word 5 a known value before the reset-suppresses-store check.
    step(1'b0, 1'b0, 1'b0, 32'd5, 32'd0, 5'd0, 1'b0, 1'b1, "init5");

    // Store 7 @10, then load it back.
    step(1'b0, 1'b0, 1'b0, 32'd10, 32'd7, 5'd24, 1'b0, 1'b1, "st10");
    step(1'b0, 1'b1, 1'b1, 32'd10, 32'd0, 5'd24, 1'b1, 1'b0, "ld10");
    check("ld10_plan_rdata", read_data_out_1, 32'd7);

    // Second location, and word 10 untouched.
    step(1'b0, 1'b0, 1'b0, 32'd20, 32'd3, 5'd2, 1'b0, 1'b1, "st20");
    step(1'b0, 1'b1, 1'b1, 32'd20, 32'd0, 5'd2, 1'b1, 1'b0, "ld20");
    step(1'b0, 1'b1, 1'b1, 32'd10, 32'd0, 5'd24, 1'b1, 1'b0, "reld10");

    // Reset edge with a store pending: outputs clear, no store.
    step(1'b1, 1'b1, 1'b1, 32'd5, 32'd9, 5'd7, 1'b1, 1'b1, "rst_st5");
    step(1'b0, 1'b1, 1'b1, 32'd5, 32'd0, 5'd7, 1'b1, 1'b0, "ld5");
    check("ld5_plan_rdata", read_data_out_1, 32'd0);

    // Read-during-write returns the old word.
    step(1'b0, 1'b0, 1'b0, 32'd30, 32'd4, 5'd3, 1'b0, 1'b1, "st30");
    step(1'b0, 1'b1, 1'b0, 32'd30, 32'd8, 5'd3, 1'b1, 1'b1, "rdw30");
    check("rdw30_plan_rdata", read_data_out_1, 32'd4);
    step(1'b0, 1'b1, 1'b1, 32'd30, 32'd0, 5'd3, 1'b1, 1'b0, "ld30");
    check("ld30_plan_rdata", read_data_out_1, 32'd8);

    // MemRead=0 gates the read data; control bits still pass.
    step(1'b0, 1'b1, 1'b0, 32'd10, 32'd0, 5'd11, 1'b0, 1'b0, "nord10");

    // Index wraps: upper address bits ignored.
    step(1'b0, 1'b0, 1'b0, 32'h0000_0107, 32'h0000_0055, 5'd4, 1'b0, 1'b1, "st_wrap");
    step(1'b0, 1'b1, 1'b1, 32'h0000_0007, 32'd0, 5'd4, 1'b1, 1'b0, "ld7");
    step(1'b0, 1'b1, 1'b1, 32'hFFFF_FF07, 32'd0, 5'd4, 1'b1, 1'b0, "ld_hi7");
    step(1'b0, 1'b0, 1'b0, 32'h0000_00FF, 32'hDEAD_BEEF, 5'd31, 1'b0, 1'b1, "st255");
    step(1'b0, 1'b1, 1'b1, 32'h0000_00FF, 32'd0, 5'd31, 1'b1, 1'b0, "ld255");

    // Random mix over a small index window so loads hit stored words.
    for (int i = 0; i < 40; i++) begin
      a = {$urandom_range(0, 3) == 0 ? 24'hABCDEF : 24'h0, 8'($urandom_range(32, 39))};
      step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom,
           5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rnd");
    end

    // Forwarding taps follow inputs mid-cycle without an edge.
    @(negedge CLK);
    RST = 1'b0;
    address = 32'h1234_5678; write_register = 5'd17; ExRegWrite_in = 1'b1;
    #1;
    check("fwd_addr_a", regExMem, 32'h1234_5678);
    check("fwd_rd_a",   {27'd0, MEMRegRd_wire}, 32'd17);
    check("fwd_rw_a",   {31'd0, MEM_RegWrite_wire}, 32'd1);
    address = 32'h8765_4321; write_register = 5'd6; ExRegWrite_in = 1'b0;
    #1;
    check("fwd_addr_b", regExMem, 32'h8765_4321);
    check("fwd_rd_b",   {27'd0, MEMRegRd_wire}, 32'd6);
    check("fwd_rw_b",   {31'd0, MEM_RegWrite_wire}, 32'd0);

    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_mem_stage
